// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, pointer-width helper and level checks.
// Also used by the async FIFO; the level-check macro is defined once here.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// True when the almost-full/almost-empty thresholds fit the given depth.
`define FIFO_LEVELS_OK(AF, AE, DEPTH) (((AF) >= 1) && ((AF) <= (DEPTH)) && ((AE) >= 0) && ((AE) < (DEPTH)))

package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Pointer width for a power-of-two depth: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_ram.sv
// Simple dual-port memory for sync_fifo_param: one write port, one registered
// read port. Contents are never reset; only the read register is.
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port; a read of the same address in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, level flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output (default: standard mode).
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LVL);

  if (!`FIFO_LEVELS_OK(AF_LVL, AE_LVL, DEPTH)) begin : g_bad_levels
    $error("sync_fifo_param: AF_LVL/AE_LVL out of range for DEPTH");
  end

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] ram_cnt;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_err;
  logic             rd_err;

  assign ram_cnt = wp - rp;

`ifdef SYNC_FIFO_FWFT_EN
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic out_valid;
  logic ram_empty;
  logic pop;

  assign ram_empty = (wp == rp);
  assign count     = ram_cnt + {{ADDR_W{1'b0}}, out_valid};
  assign full      = (count == DEPTH_C);
  assign empty     = (count == {(ADDR_W+1){1'b0}});

  // Output stage refills from memory whenever it is empty or being popped.
  always_comb begin
    pop    = read && out_valid;
    rd_ok  = !ram_empty && (!out_valid || pop);
    wr_ok  = write && (!full || pop);
    wr_err = write && !wr_ok;
    rd_err = read && !out_valid;
  end

  // Occupancy of the single output register stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
    end else if (rd_ok) begin
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end
`else
  logic out_valid;

  assign count = ram_cnt;
  assign full  = (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  assign empty = (wp == rp);

  // A simultaneous read frees a slot, so a full FIFO still accepts the write.
  always_comb begin
    rd_ok  = read && !empty;
    wr_ok  = write && (!full || rd_ok);
    wr_err = write && !wr_ok;
    rd_err = read && empty;
  end

  // oValid marks the cycle right after an accepted read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_ok;
    end
  end
`endif

  assign oValid       = out_valid;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Pointer advance; both wrap naturally through the extra MSB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp <= {PTR_W{1'b0}};
      rp <= {PTR_W{1'b0}};
    end else begin
      wp <= wr_ok ? wp + {{(PTR_W-1){1'b0}}, 1'b1} : wp;
      rp <= rd_ok ? rp + {{(PTR_W-1){1'b0}}, 1'b1} : rp;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | wr_err;
      underflow <= underflow | rd_err;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_ok && !RST),
    .waddr (wp[ADDR_W-1:0]),
    .wdata (iData),
    .re    (rd_ok && !RST),
    .raddr (rp[ADDR_W-1:0]),
    .rdata (oData)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param in its default configuration
// (DATA_W=8, ADDR_W=4, AF_LVL=12, AE_LVL=2, standard read mode).
module tb_sync_fifo_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] iData = 8'h00;
  logic [7:0] oData;
  logic       oValid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int tests  = 0;
  int failed = 0;

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] d;
  logic       r;
  int         wr_n;

  sync_fifo_param dut (
    .CLK          (CLK),
    .RST          (RST),
    .write        (write),
    .read         (read),
    .iData        (iData),
    .oData        (oData),
    .oValid       (oValid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then sample 1 time unit later.
  task automatic step(input logic w, input logic rd, input logic [7:0] din, input logic rst = 1'b0);
    write = w;
    read  = rd;
    iData = din;
    RST   = rst;
    @(posedge CLK);
    #1;
    write = 1'b0;
    read  = 1'b0;
    RST   = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int n);
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_full"}, 32'(full), 32'(n == 16));
    chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
    chk({tag, "_af"}, 32'(almost_full), 32'(n >= 12));
    chk({tag, "_ae"}, 32'(almost_empty), 32'(n <= 2));
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    chk_flags("rst", 0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_odata", 32'(oData), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk_flags("fill", i);
      chk("fill_ovf", 32'(overflow), 32'd0);
    end
    step(1'b1, 1'b0, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk_flags("ovf", 16);

    // Drain: data in order, one cycle after each read
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_valid", 32'(oValid), 32'd1);
      chk("drain_data", 32'(oData), 32'(i));
      chk_flags("drain", 16 - i);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("idle_valid", 32'(oValid), 32'd0);
    chk("idle_hold", 32'(oData), 32'h10);
    chk("pre_udf", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_valid", 32'(oValid), 32'd0);
    chk("udf_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous write and read
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    chk("rst2_udf", 32'(underflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(8'h21 + i));
    end
    chk_flags("full2", 16);
    step(1'b1, 1'b1, 8'hAA);
    chk_flags("fullwr", 16);
    chk("fullwr_ovf", 32'(overflow), 32'd0);
    chk("fullwr_valid", 32'(oValid), 32'd1);
    chk("fullwr_data", 32'(oData), 32'h21);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("full_drain", 32'(oData), (i == 15) ? 32'hAA : 32'(8'h22 + i));
    end
    chk_flags("full_drained", 0);

    // Empty with simultaneous write and read
    step(1'b1, 1'b1, 8'h55);
    chk("emptywr_count", 32'(count), 32'd1);
    chk("emptywr_udf", 32'(underflow), 32'd1);
    chk("emptywr_valid", 32'(oValid), 32'd0);
    chk("emptywr_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("emptywr_data", 32'(oData), 32'h55);
    chk("emptywr_rvalid", 32'(oValid), 32'd1);
    chk("emptywr_count0", 32'(count), 32'd0);

    // Interleaved traffic wrapping the pointers, scoreboard-checked
    step(1'b0, 1'b0, 8'h00, 1'b1);
    q.delete();
    wr_n = 0;
    while (wr_n < 40) begin
      r = (q.size() >= 10) || (q.size() > 3 && wr_n[0]);
      d = 8'(8'h80 + wr_n);
      step(1'b1, r, d);
      if (r) begin
        exp_d = q.pop_front();
        chk("wrap_data", 32'(oData), 32'(exp_d));
      end
      chk("wrap_valid", 32'(oValid), 32'(r));
      q.push_back(d);
      wr_n++;
      chk_flags("wrap", q.size());
    end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 8'h00);
      exp_d = q.pop_front();
      chk("wdrain_data", 32'(oData), 32'(exp_d));
      chk_flags("wdrain", q.size());
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_udf", 32'(underflow), 32'd0);

    // Reset mid-burst at count 7
    step(1'b0, 1'b1, 8'h00);
    chk("mid_udf_pre", 32'(underflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'(8'h70 + i));
    end
    step(1'b0, 1'b1, 8'h00);
    chk("mid_pre_data", 32'(oData), 32'h70);
    step(1'b1, 1'b0, 8'h77);
    chk("mid_pre_count", 32'(count), 32'd7);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk_flags("mid_rst", 0);
    chk("mid_rst_valid", 32'(oValid), 32'd0);
    chk("mid_rst_odata", 32'(oData), 32'h00);
    chk("mid_rst_udf", 32'(underflow), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b0, 8'h99);
    chk("post_count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("post_data", 32'(oData), 32'h99);
    chk("post_valid", 32'(oValid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
